shift_operand_sequencer: RTL and testbench

Command-driven sequencer that sits directly upstream and downstream of the initial shift processor in the sparse polynomial multiplier. Per command it:
- fetches dense-polynomial words 0, 551 and 552 and one accumulator word from single-port synchronous RAMs;
- presents them with the derived shift index to the processor and pulses `start_process`;
- waits for `processing_done` and writes `result` back to the same accumulator address.

It serialises all accesses so the processor never sees changing operands mid-operation.

---
 rtl/shift_operand_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_shift_operand_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_sequencer.sv
// Operand fetch / start / write-back sequencer around the initial shift
// processor of the sparse polynomial multiplier.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   cmd_*               command handshake (shift amount, accumulator index)
//   dense_rd_*          dense polynomial RAM read port (1-cycle latency)
//   acc_rd_*, acc_wr_*  accumulator RAM read / write ports
//   normal_word_*, acc_word_i, shift, acc_shift_idx, start_process
//                       registered operands and start pulse to the processor
//   result, processing_done
//                       processor response
//   done, busy, err     status: completion pulse, busy, sticky error
module shift_operand_sequencer #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int LAST_WORD_IDX  = 552,
  parameter int LAST_WORD_BITS = 5,
  parameter int DONE_TIMEOUT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [15:0]           cmd_shift,
  input  logic [ADDR_WIDTH-1:0] cmd_acc_idx,
  output logic                  dense_rd_en,
  output logic [ADDR_WIDTH-1:0] dense_rd_addr,
  input  logic [WORD_WIDTH-1:0] dense_rd_data,
  output logic                  acc_rd_en,
  output logic [ADDR_WIDTH-1:0] acc_rd_addr,
  input  logic [WORD_WIDTH-1:0] acc_rd_data,
  output logic [WORD_WIDTH-1:0] normal_word_zero,
  output logic [WORD_WIDTH-1:0] normal_word_551,
  output logic [WORD_WIDTH-1:0] normal_word_552,
  output logic [WORD_WIDTH-1:0] acc_word_i,
  output logic [15:0]           shift,
  output logic [4:0]            acc_shift_idx,
  output logic                  start_process,
  input  logic [WORD_WIDTH-1:0] result,
  input  logic                  processing_done,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic [WORD_WIDTH-1:0] acc_wr_data,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int WDW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2,
    S_CAP, S_START, S_WAIT, S_WRITE
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [15:0]           shift_q;
  logic [4:0]            sidx_q;
  logic [WORD_WIDTH-1:0] w0_q, w551_q, w552_q, acc_q;
  logic [WORD_WIDTH-1:0] wdata_q;
  logic [WDW-1:0]        wd_q;
  logic                  err_q;
  logic                  abort_q;
  logic                  live_q;

  logic       accept;
  logic       idx_bad;
  logic       wd_expired;
  logic [4:0] sh5;
  logic [4:0] sidx_d;

  assign accept     = cmd_valid && cmd_ready;
  assign idx_bad    = cmd_acc_idx > ADDR_WIDTH'(LAST_WORD_IDX);
  assign wd_expired = wd_q == WDW'(DONE_TIMEOUT - 1);
  assign sh5        = cmd_shift[4:0];
  assign sidx_d     = (sh5 >= 5'(LAST_WORD_BITS))
                    ? sh5 - 5'(LAST_WORD_BITS) : sh5;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state. Aborted commands (bad index, watchdog) still pass through
  // WRITE so done pulses on the same relative cycle; abort_q masks the write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = idx_bad ? S_WRITE : S_RD0;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_CAP;
      S_CAP:   state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (processing_done || wd_expired) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    dense_rd_en   = 1'b0;
    dense_rd_addr = '0;
    acc_rd_en     = 1'b0;
    acc_rd_addr   = '0;
    start_process = 1'b0;
    acc_wr_en     = 1'b0;
    acc_wr_addr   = '0;
    done          = 1'b0;
    unique case (state_q)
      S_RD0: begin
        dense_rd_en = 1'b1;
        acc_rd_en   = 1'b1;
        acc_rd_addr = idx_q;
      end
      S_RD1: begin
        dense_rd_en   = 1'b1;
        dense_rd_addr = ADDR_WIDTH'(LAST_WORD_IDX - 1);
      end
      S_RD2: begin
        dense_rd_en   = 1'b1;
        dense_rd_addr = ADDR_WIDTH'(LAST_WORD_IDX);
      end
      S_START: start_process = 1'b1;
      S_WRITE: begin
        done = 1'b1;
        if (!abort_q) begin
          acc_wr_en   = 1'b1;
          acc_wr_addr = idx_q;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready        = (state_q == S_IDLE) && live_q;
  assign busy             = state_q != S_IDLE;
  assign err              = err_q;
  assign normal_word_zero = w0_q;
  assign normal_word_551  = w551_q;
  assign normal_word_552  = w552_q;
  assign acc_word_i       = acc_q;
  assign shift            = shift_q;
  assign acc_shift_idx    = sidx_q;
  assign acc_wr_data      = wdata_q;

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= '0;
      shift_q <= '0;
      sidx_q  <= '0;
      w0_q    <= '0;
      w551_q  <= '0;
      w552_q  <= '0;
      acc_q   <= '0;
      wdata_q <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      // Holds cmd_ready low for the first edge after reset release
      live_q <= 1'b1;
      if (accept) begin
        idx_q   <= cmd_acc_idx;
        shift_q <= cmd_shift;
        sidx_q  <= sidx_d;
        abort_q <= idx_bad;
        if (idx_bad) err_q <= 1'b1;
      end
      if (state_q == S_RD1) begin
        w0_q  <= dense_rd_data;
        acc_q <= acc_rd_data;
      end
      if (state_q == S_RD2) w551_q <= dense_rd_data;
      if (state_q == S_CAP) w552_q <= dense_rd_data;
      if (state_q == S_START) wd_q <= '0;
      if (state_q == S_WAIT) begin
        wd_q <= wd_q + 1'b1;
        if (processing_done) begin
          wdata_q <= result;
        end else if (wd_expired) begin
          err_q   <= 1'b1;
          abort_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Randomized self-checking bench for shift_operand_sequencer with
// behavioural RAM, processor and timing reference models.
module tb_shift_operand_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_shift = '0;
  logic [9:0]  cmd_acc_idx = '0;
  logic        dense_rd_en;
  logic [9:0]  dense_rd_addr;
  logic [31:0] dense_rd_data = '0;
  logic        acc_rd_en;
  logic [9:0]  acc_rd_addr;
  logic [31:0] acc_rd_data = '0;
  logic [31:0] normal_word_zero, normal_word_551, normal_word_552;
  logic [31:0] acc_word_i;
  logic [15:0] shift;
  logic [4:0]  acc_shift_idx;
  logic        start_process;
  logic [31:0] result = '0;
  logic        processing_done = 1'b0;
  logic        acc_wr_en;
  logic [9:0]  acc_wr_addr;
  logic [31:0] acc_wr_data;
  logic        done, busy, err;

  shift_operand_sequencer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_shift(cmd_shift), .cmd_acc_idx(cmd_acc_idx),
    .dense_rd_en(dense_rd_en), .dense_rd_addr(dense_rd_addr),
    .dense_rd_data(dense_rd_data),
    .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
    .acc_rd_data(acc_rd_data),
    .normal_word_zero(normal_word_zero),
    .normal_word_551(normal_word_551),
    .normal_word_552(normal_word_552),
    .acc_word_i(acc_word_i), .shift(shift),
    .acc_shift_idx(acc_shift_idx),
    .start_process(start_process),
    .result(result), .processing_done(processing_done),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_data(acc_wr_data),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit err_exp = 1'b0;

  logic [31:0] dense_mem [0:1023];
  logic [31:0] acc_mem   [0:1023];

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{cmd_ready, dense_rd_en, dense_rd_addr, acc_rd_en,
             acc_rd_addr, normal_word_zero, normal_word_551,
             normal_word_552, acc_word_i, shift, acc_shift_idx,
             start_process, acc_wr_en, acc_wr_addr, acc_wr_data,
             done, busy, err};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_outs_zero", 64'(any_out()), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    err_exp = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 1);
    check("rst_err", 64'(err), 0);
  endtask

  // Issue one command from just after a negedge with cmd_ready high.
  // lat = processor latency in cycles after start (0 = never answers).
  // keep = leave cmd_valid high so the next command follows at once.
  task automatic run_cmd(input logic [15:0] sh, input logic [9:0] idx,
                         input int lat, input bit keep);
    int st_c, wr_c, dn_c, rdy_c, clash, wr_cnt, rd_cnt, st_cnt;
    int sm, e_sidx, e_wr, e_rdy;
    logic [31:0] res, wdata, e_acc;
    logic [9:0]  waddr, pd_addr, pa_addr;
    logic [31:0] o0, o551, o552, oacc;
    logic [15:0] osh;
    logic [4:0]  osidx;
    bit ok_rng, ok_lat, pd_en, pa_en;
    res = $urandom;
    ok_rng = idx <= 10'd552;
    ok_lat = lat >= 1 && lat <= 15;
    e_acc = acc_mem[idx];
    sm = int'(sh % 16'd32);
    e_sidx = (sm >= 5) ? sm - 5 : sm;
    st_c = -1; wr_c = -1; dn_c = -1; rdy_c = -1;
    clash = 0; wr_cnt = 0; rd_cnt = 0; st_cnt = 0;
    pd_en = 0; pa_en = 0; pd_addr = '0; pa_addr = '0;
    waddr = '0; wdata = '0;
    o0 = '0; o551 = '0; o552 = '0; oacc = '0; osh = '0; osidx = '0;
    check("pre_ready", 64'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_shift = sh;
    cmd_acc_idx = idx;
    for (int n = 1; n <= 40 && rdy_c < 0; n++) begin
      @(negedge clk);
      if (!keep) cmd_valid = 1'b0;
      dense_rd_data = pd_en ? dense_mem[pd_addr] : $urandom;
      acc_rd_data   = pa_en ? acc_mem[pa_addr] : $urandom;
      pd_en = dense_rd_en; pd_addr = dense_rd_addr;
      pa_en = acc_rd_en;   pa_addr = acc_rd_addr;
      if (dense_rd_en || acc_rd_en) rd_cnt++;
      if ((dense_rd_en || acc_rd_en) && acc_wr_en) clash++;
      if (start_process) begin
        st_cnt++;
        st_c = n;
        o0 = normal_word_zero; o551 = normal_word_551;
        o552 = normal_word_552; oacc = acc_word_i;
        osh = shift; osidx = acc_shift_idx;
      end
      if (acc_wr_en) begin
        wr_cnt++; wr_c = n; waddr = acc_wr_addr; wdata = acc_wr_data;
      end
      if (done) dn_c = n;
      if (cmd_ready) rdy_c = n;
      processing_done = lat > 0 && st_c > 0 && n == st_c + lat;
      result = processing_done ? res : $urandom;
    end
    processing_done = 1'b0;
    if (!ok_rng) begin
      err_exp = 1'b1;
      check("bad_starts", 64'(st_cnt), 0);
      check("bad_reads", 64'(rd_cnt), 0);
      check("bad_writes", 64'(wr_cnt), 0);
      check("bad_done_cyc", 64'(dn_c), 1);
      check("bad_ready_cyc", 64'(rdy_c), 2);
    end else begin
      check("start_cyc", 64'(st_c), 5);
      check("start_cnt", 64'(st_cnt), 1);
      check("op_w0", 64'(o0), 64'(dense_mem[0]));
      check("op_w551", 64'(o551), 64'(dense_mem[551]));
      check("op_w552", 64'(o552), 64'(dense_mem[552]));
      check("op_acc", 64'(oacc), 64'(e_acc));
      check("op_shift", 64'(osh), 64'(sh));
      check("op_sidx", 64'(osidx), 64'(e_sidx));
      check("read_cycles", 64'(rd_cnt), 3);
      check("rd_wr_clash", 64'(clash), 0);
      if (ok_lat) begin
        e_wr = 6 + lat;
        check("wr_cyc", 64'(wr_c), 64'(e_wr));
        check("wr_cnt", 64'(wr_cnt), 1);
        check("wr_addr", 64'(waddr), 64'(idx));
        check("wr_data", 64'(wdata), 64'(res));
        acc_mem[idx] = res;
      end else begin
        e_wr = 21;
        err_exp = 1'b1;
        check("wd_writes", 64'(wr_cnt), 0);
      end
      e_rdy = e_wr + 1;
      check("done_cyc", 64'(dn_c), 64'(e_wr));
      check("ready_cyc", 64'(rdy_c), 64'(e_rdy));
      check("hold_w0", 64'(normal_word_zero), 64'(dense_mem[0]));
      check("hold_acc", 64'(acc_word_i), 64'(e_acc));
    end
    check("err_flag", 64'(err), 64'(err_exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int stray;
    for (int i = 0; i < 1024; i++) begin
      dense_mem[i] = $urandom;
      acc_mem[i]   = $urandom;
    end
    do_reset();

    dense_mem[0]   = 32'hFFFF_FFFF;
    dense_mem[551] = 32'h1234_5678;
    dense_mem[552] = 32'h0000_001F;
    acc_mem[7]     = 32'hA5A5_A5A5;
    run_cmd(16'd3, 10'd7, 3, 1'b0);

    run_cmd(16'h0013, 10'd100, 3, 1'b0);
    run_cmd(16'h0025, 10'd552, 2, 1'b0);
    run_cmd(16'h0004, 10'd0, 1, 1'b0);

    for (int i = 0; i < 12; i++)
      run_cmd(16'($urandom), 10'($urandom_range(0, 552)),
              $urandom_range(1, 10), 1'b0);

    // Answer in the last allowed WAIT cycle: write wins over watchdog
    run_cmd(16'($urandom), 10'd33, 15, 1'b0);
    // Processor never answers
    run_cmd(16'($urandom), 10'd34, 0, 1'b0);
    // Out-of-range index
    run_cmd(16'd9, 10'd553, 3, 1'b0);

    // Reset while waiting on the processor
    do_reset();
    cmd_valid = 1'b1; cmd_shift = 16'd6; cmd_acc_idx = 10'd12;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_busy", 64'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_zero", 64'(any_out()), 0);
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (acc_wr_en || done) stray++;
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_no_wr_done", 64'(stray), 0);
    check("mid_ready", 64'(cmd_ready), 1);
    run_cmd(16'd21, 10'd12, 4, 1'b0);

    // Stray processing_done while idle
    stray = 0;
    processing_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (acc_wr_en || done || busy) stray++;
    end
    processing_done = 1'b0;
    @(negedge clk);
    check("stray_pdone", 64'(stray), 0);

    // Back-to-back with cmd_valid held
    run_cmd(16'd17, 10'd200, 3, 1'b1);
    run_cmd(16'd30, 10'd201, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
